// File: rtl/breath_seq_ctrl_if.sv
// Control/observation bundle for the breathing-LED sequencer.
// master: whoever issues start/stop and watches the outputs; slave: the sequencer.
interface breath_seq_ctrl_if #(
  parameter int PWM_STEPS = 1000
);
  localparam int DW = $clog2(PWM_STEPS + 1);

  logic          start;
  logic          stop;
  logic [7:0]    num_cycles;
  logic          led;
  logic          busy;
  logic          done;
  logic [2:0]    phase;
  logic [DW-1:0] duty;

  modport master (
    output start, stop, num_cycles,
    input  led, busy, done, phase, duty
  );

  modport slave (
    input  start, stop, num_cycles,
    output led, busy, done, phase, duty
  );
endinterface

// File: rtl/breath_seq_ctrl.sv
// Breathing-LED sequencer: fade in, hold on, fade out, hold off, repeated for
// a latched number of breaths (0 = forever). Owns its 2 us time base and PWM
// frame; a stop request drains the LED down gracefully instead of cutting it.
module breath_seq_ctrl #(
  parameter int CNT_2US_MAX  = 100,
  parameter int PWM_STEPS    = 1000,
  parameter int HOLD_PERIODS = 250
) (
  input logic              clk,
  input logic              rstn,
  breath_seq_ctrl_if.slave bus
);

  localparam int DW = $clog2(PWM_STEPS + 1);
  localparam int PW = (CNT_2US_MAX > 1) ? $clog2(CNT_2US_MAX) : 1;
  localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [PW-1:0] PRESC_TOP = PW'(CNT_2US_MAX - 1);
  localparam logic [DW-1:0] PWM_TOP   = DW'(PWM_STEPS - 1);
  localparam logic [DW-1:0] DUTY_MAX  = DW'(PWM_STEPS);
  localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_PERIODS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    HOLD_ON  = 3'd2,
    FADE_OUT = 3'd3,
    HOLD_OFF = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]    cyc_cnt_q, cyc_cnt_d;
  logic [7:0]    num_cyc_q, num_cyc_d;
  logic          stop_pend_q, stop_pend_d;
  logic          led_q, led_d;
  logic          done_q, done_d;

  logic       busy;
  logic       tick;
  logic       frame_end;
  logic       go_idle;
  logic [7:0] cyc_inc;

  assign busy      = (state_q != IDLE);
  assign tick      = busy && (presc_q == PRESC_TOP);
  assign frame_end = tick && (pwm_cnt_q == PWM_TOP);
  assign cyc_inc   = cyc_cnt_q + 8'd1;

  // Next-state and datapath: frame-end progress first, then the stop rule on the result.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    presc_d     = presc_q;
    pwm_cnt_d   = pwm_cnt_q;
    duty_d      = duty_q;
    hold_cnt_d  = hold_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    num_cyc_d   = num_cyc_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    go_idle     = 1'b0;

    if (state_q == IDLE) begin
      // A simultaneous stop cancels the start; a lone stop is meaningless here.
      if (bus.start && !bus.stop) begin
        state_d    = FADE_IN;
        presc_d    = '0;
        pwm_cnt_d  = '0;
        duty_d     = '0;
        hold_cnt_d = '0;
        cyc_cnt_d  = '0;
        num_cyc_d  = bus.num_cycles;
      end
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        pwm_cnt_d = (pwm_cnt_q == PWM_TOP) ? '0 : pwm_cnt_q + DW'(1);
      end

      if (frame_end) begin
        case (state_q)
          FADE_IN: begin
            if (duty_q == PWM_TOP) begin
              duty_d  = DUTY_MAX;
              state_d = HOLD_ON;
            end else begin
              duty_d = duty_q + DW'(1);
            end
          end
          HOLD_ON: begin
            if (hold_cnt_q == HOLD_TOP) begin
              hold_cnt_d = '0;
              state_d    = FADE_OUT;
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end
          FADE_OUT: begin
            if (duty_q == DW'(1)) begin
              duty_d = '0;
              if (stop_pend_q) go_idle = 1'b1;
              else             state_d = HOLD_OFF;
            end else begin
              duty_d = duty_q - DW'(1);
            end
          end
          HOLD_OFF: begin
            if (hold_cnt_q == HOLD_TOP) begin
              hold_cnt_d = '0;
              if (num_cyc_q != 8'd0 && cyc_inc == num_cyc_q) begin
                go_idle = 1'b1;
              end else begin
                cyc_cnt_d = cyc_inc;
                state_d   = FADE_IN;
              end
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end
          default: ;
        endcase
      end

      // Graceful stop: ramp down from wherever the duty is; nothing lit means stop at once.
      if (bus.stop && !go_idle) begin
        case (state_d)
          FADE_IN, HOLD_ON: begin
            if (duty_d == '0) begin
              go_idle = 1'b1;
            end else begin
              state_d     = FADE_OUT;
              hold_cnt_d  = '0;
              stop_pend_d = 1'b1;
            end
          end
          FADE_OUT: stop_pend_d = 1'b1;
          HOLD_OFF: go_idle     = 1'b1;
          default:  ;
        endcase
      end

      if (go_idle) begin
        state_d     = IDLE;
        presc_d     = '0;
        pwm_cnt_d   = '0;
        duty_d      = '0;
        hold_cnt_d  = '0;
        stop_pend_d = 1'b0;
        done_d      = 1'b1;
      end
    end

    led_d = busy && (pwm_cnt_q < duty_q);
  end

  // State and datapath registers; reset aborts silently (no done pulse).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      hold_cnt_q  <= '0;
      cyc_cnt_q   <= '0;
      num_cyc_q   <= '0;
      stop_pend_q <= 1'b0;
      led_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
      state_q     <= state_d;
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      hold_cnt_q  <= hold_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      num_cyc_q   <= num_cyc_d;
      stop_pend_q <= stop_pend_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.busy  = busy;
  assign bus.done  = done_q;
  assign bus.phase = state_q;
  assign bus.duty  = duty_q;

endmodule

// File: tb/tb_breath_seq_ctrl.sv
// Scoreboard bench for breath_seq_ctrl with a small configuration
// (frame = 8 cycles, breath = 96 cycles). Expected per-cycle outputs of each
// run are derived from the breath timeline arithmetic and queued; a monitor
// pops one entry for every cycle the DUT shows busy or done.
module tb_breath_seq_ctrl;

  localparam int CNT    = 2;
  localparam int PWM    = 4;
  localparam int HOLD   = 2;
  localparam int FRAME  = CNT * PWM;
  localparam int FPB    = 2 * PWM + 2 * HOLD;
  localparam int BREATH = FPB * FRAME;

  typedef struct packed {
    logic       busy;
    logic [2:0] phase;
    logic [2:0] duty;
    logic       led;
    logic       done;
  } exp_t;

  logic clk;
  logic rstn;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  breath_seq_ctrl_if #(.PWM_STEPS(PWM)) bus ();

  breath_seq_ctrl #(
    .CNT_2US_MAX (CNT),
    .PWM_STEPS   (PWM),
    .HOLD_PERIODS(HOLD)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Undisturbed schedule at cycle t after an accepted start.
  function automatic void norm_at(input int t, input int n, output bit b, output int ph, output int d);
    int f;
    if (n != 0 && t >= n * BREATH) begin
      b = 0; ph = 0; d = 0;
      return;
    end
    b = 1;
    f = (t / FRAME) % FPB;
    if (f < PWM) begin
      ph = 1; d = f;
    end else if (f < PWM + HOLD) begin
      ph = 2; d = PWM;
    end else if (f < 2 * PWM + HOLD) begin
      ph = 3; d = PWM - (f - PWM - HOLD);
    end else begin
      ph = 4; d = 0;
    end
  endfunction

  // Queue the expected trace of one run (optional stop during cycle ts); returns the IDLE cycle.
  function automatic int build_run(input int n, input int ts);
    int  end_t, d0, dec_from, ph, d, pwm;
    bit  b, pb;
    int  p_pwm, p_d;
    exp_t e;
    end_t    = (n != 0) ? n * BREATH : 32'h4000_0000;
    d0       = 0;
    dec_from = -1;
    if (ts >= 0) begin
      norm_at(ts + 1, n, b, ph, d);
      if (b) begin
        if (ph == 4 || (ph == 1 && d == 0)) begin
          end_t = ts + 1;
        end else begin
          d0       = d;
          dec_from = ts + 1;
          end_t    = ((ts + 1) / FRAME + 1) * FRAME + FRAME * (d0 - 1);
        end
      end
    end
    pb = 0; p_pwm = 0; p_d = 0;
    for (int t = 0; t <= end_t; t++) begin
      if (t == end_t) begin
        b = 0; ph = 0; d = 0;
      end else if (dec_from >= 0 && t >= dec_from) begin
        b = 1; ph = 3; d = d0 - (t / FRAME - dec_from / FRAME);
      end else begin
        norm_at(t, n, b, ph, d);
      end
      pwm     = (t % FRAME) / CNT;
      e.busy  = b;
      e.phase = 3'(ph);
      e.duty  = 3'(d);
      e.led   = pb && (p_pwm < p_d);
      e.done  = (t == end_t);
      exp_q.push_back(e);
      pb = b; p_pwm = pwm; p_d = d;
    end
    return end_t;
  endfunction

  // Monitor: one scoreboard entry per cycle in which the DUT shows activity.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && (bus.busy === 1'b1 || bus.done === 1'b1)) begin
        if (exp_q.size() == 0) begin
          check("spurious_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("busy",  bus.busy,  e.busy);
          check("phase", bus.phase, e.phase);
          check("duty",  bus.duty,  e.duty);
          check("led",   bus.led,   e.led);
          check("done",  bus.done,  e.done);
        end
      end
    end
  end

  task automatic expect_idle(input string name, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      check({name, "_busy"},  bus.busy,  32'd0);
      check({name, "_phase"}, bus.phase, 32'd0);
      check({name, "_duty"},  bus.duty,  32'd0);
      check({name, "_led"},   bus.led,   32'd0);
      check({name, "_done"},  bus.done,  32'd0);
    end
  endtask

  // One run: start with n breaths, optional stop in cycle ts, optional ignored start in cycle dup_at.
  task automatic run(input int n, input int ts, input int dup_at);
    int end_t;
    int dup;
    end_t = build_run(n, ts);
    dup   = (dup_at < end_t) ? dup_at : -1;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.num_cycles = 8'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c <= end_t + 2; c++) begin
      bus.stop  = (c == ts);
      bus.start = (c == dup);
      if (c == 1) bus.num_cycles = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, ts, dup;
    n_checks       = 0;
    n_fail         = 0;
    rstn           = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.num_cycles = 8'd0;

    // Reset held with clock running, released mid-period.
    expect_idle("in_reset", 3);
    @(posedge clk); #3;
    rstn = 1'b1;
    expect_idle("after_reset", 3);

    // Single breath, multi-breath, infinite with late stop.
    run(1, -1, -1);
    run(3, -1, -1);
    run(0, 1010, -1);

    // Graceful stop at duty 2 in FADE_IN; stops in HOLD_ON, FADE_OUT, HOLD_OFF;
    // stop coincident with frame ends; stop before first frame end.
    run(1, 18, -1);
    run(1, 37, -1);
    run(1, 60, -1);
    run(2, 85, -1);
    run(1, 7, -1);
    run(1, 31, -1);
    run(2, 95, -1);
    run(1, 0, -1);

    // Stop alone in IDLE, start+stop together in IDLE.
    @(posedge clk); #1; bus.stop = 1'b1;
    @(posedge clk); #1; bus.stop = 1'b0;
    expect_idle("stop_in_idle", 3);
    @(posedge clk); #1; bus.stop = 1'b1; bus.start = 1'b1; bus.num_cycles = 8'd1;
    @(posedge clk); #1; bus.stop = 1'b0; bus.start = 1'b0;
    expect_idle("start_stop_idle", 3);

    // Start while busy is ignored (also mid-HOLD_OFF and on the last busy cycle).
    run(1, -1, 40);
    run(2, -1, 90);
    run(1, -1, 95);

    // Async reset during HOLD_ON: outputs drop without a clock edge, no done.
    void'(build_run(1, -1));
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.num_cycles = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    check("pre_reset_led", bus.led, 32'd1);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("async_led",   bus.led,   32'd0);
    check("async_phase", bus.phase, 32'd0);
    check("async_busy",  bus.busy,  32'd0);
    expect_idle("reset_hold", 3);
    @(posedge clk); #3;
    rstn = 1'b1;
    expect_idle("reset_release", 3);
    run(1, -1, -1);

    // Randomized runs.
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 3);
      if (n == 0)                       ts = $urandom_range(0, 400);
      else if ($urandom_range(0, 1) == 1) ts = -1;
      else                              ts = $urandom_range(0, n * BREATH - 1);
      dup = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 200) : -1;
      run(n, ts, dup);
    end

    expect_idle("final", 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
